// File: rtl/afifo_wr_arb.sv
// Round-robin write arbiter: X requesters share one FIFO write port.
// A grant holds for up to B transfers and then rotates to the next requester.
module afifo_wr_arb #(
    parameter int W  = 16,
    parameter int X  = 2,
    parameter int B  = 4,
    parameter int SW = $clog2(X)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [X*W-1:0]  reqdata,
    input  logic [X-1:0]    reqvld,
    output logic [X-1:0]    reqrdy,
    output logic [W-1:0]    wrdata,
    output logic [SW-1:0]   wrsrc,
    output logic            wrvld,
    input  logic            wrrdy,
    output logic            busy
);

    localparam int BW = $clog2(B) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  gnt_q, gnt_d;
    logic [SW-1:0]  last_q, last_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic           xfer;
    logic           rel;

    // First requesting index strictly after prev, wrapping at X.
    function automatic logic [SW-1:0] rr_pick(input logic [SW-1:0] prev,
                                              input logic [X-1:0]  vld);
        logic [SW-1:0] pick;
        int            idx;
        pick = prev;
        for (int off = X; off >= 1; off--) begin
            idx = (int'(prev) + off) % X;
            if (vld[idx]) begin
                pick = SW'(idx);
            end
        end
        return pick;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            beat_q  <= '0;
            last_q  <= SW'(X - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        beat_d  = beat_q;
        last_d  = last_q;
        xfer    = 1'b0;
        rel     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|reqvld) begin
                    state_d = GRANT;
                    gnt_d   = rr_pick(last_q, reqvld);
                    beat_d  = '0;
                end
            end
            GRANT: begin
                xfer = reqvld[gnt_q] && wrrdy;
                if (xfer) begin
                    beat_d = beat_q + BW'(1);
                end
                rel = !reqvld[gnt_q] || (xfer && (beat_q == BW'(B - 1)));
                // Re-arbitrate in the release cycle so back-to-back bursts have no bubble.
                if (rel) begin
                    last_d = gnt_q;
                    beat_d = '0;
                    if (|reqvld) begin
                        gnt_d = rr_pick(gnt_q, reqvld);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        reqrdy = '0;
        wrdata = '0;
        wrsrc  = '0;
        wrvld  = 1'b0;
        busy   = 1'b0;
        if (!rst && (state_q == GRANT)) begin
            wrdata        = reqdata[int'(gnt_q)*W +: W];
            wrsrc         = gnt_q;
            wrvld         = reqvld[gnt_q];
            reqrdy[gnt_q] = wrrdy;
            busy          = 1'b1;
        end
    end

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Bench for afifo_wr_arb: four X=3 instances with B=1..4 share one stimulus stream,
// each checked every cycle against a burst-level round-robin model and a word scoreboard.
module tb_afifo_wr_arb;

    localparam int W  = 16;
    localparam int X  = 3;
    localparam int NI = 4;
    localparam int SW = $clog2(X);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wrrdy = 1'b0;
    logic [X-1:0]    reqvld = '0;
    logic [X*W-1:0]  reqdata_a [NI];
    logic [X-1:0]    reqrdy_a  [NI];
    logic [W-1:0]    wrdata_a  [NI];
    logic [SW-1:0]   wrsrc_a   [NI];
    logic            wrvld_a   [NI];
    logic            busy_a    [NI];

    int              m_busy  [NI];
    int              m_owner [NI];
    int              m_cnt   [NI];
    int              m_last  [NI];
    logic [7:0]      seq_drv [NI][X];
    logic [7:0]      exp_seq [NI][X];
    int              waitc   [NI][X];
    int              run_src [NI];
    int              run_len [NI];
    int              n_checks = 0;
    int              n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        afifo_wr_arb #(.W(W), .X(X), .B(g + 1), .SW(SW)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .reqdata (reqdata_a[g]),
            .reqvld  (reqvld),
            .reqrdy  (reqrdy_a[g]),
            .wrdata  (wrdata_a[g]),
            .wrsrc   (wrsrc_a[g]),
            .wrvld   (wrvld_a[g]),
            .wrrdy   (wrrdy),
            .busy    (busy_a[g])
        );
    end

    // Next requester after prev in rotation order, or -1 if nobody asks.
    function automatic int rr(input int prev, input logic [X-1:0] v);
        int r;
        r = -1;
        for (int j = X; j >= 1; j--) begin
            if (v[(prev + j) % X]) r = (prev + j) % X;
        end
        return r;
    endfunction

    task automatic checkLit(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s dut%0d t=%0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        for (int k = 0; k < NI; k++) begin
            int            bk;
            int            s;
            logic          fire;
            logic [X-1:0]  e_rdy;
            logic [W-1:0]  e_data;
            logic [SW-1:0] e_src;
            logic          e_vld;
            logic          e_busy;
            logic [W-1:0]  e_word;
            bk     = k + 1;
            e_rdy  = '0;
            e_data = '0;
            e_src  = '0;
            e_vld  = 1'b0;
            e_busy = 1'b0;
            if (!rst && (m_busy[k] != 0)) begin
                e_busy = 1'b1;
                e_src  = SW'(m_owner[k]);
                e_vld  = reqvld[m_owner[k]];
                e_data = reqdata_a[k][m_owner[k]*W +: W];
                if (wrrdy) e_rdy[m_owner[k]] = 1'b1;
            end
            n_checks++;
            if ({reqrdy_a[k], wrdata_a[k], wrsrc_a[k], wrvld_a[k], busy_a[k]} !==
                {e_rdy, e_data, e_src, e_vld, e_busy}) begin
                n_fail++;
                $display("[TB] FAIL model_cmp dut%0d t=%0t: got rdy=%b data=%h src=%0d vld=%b busy=%b expected rdy=%b data=%h src=%0d vld=%b busy=%b",
                         k, $time, reqrdy_a[k], wrdata_a[k], wrsrc_a[k], wrvld_a[k], busy_a[k],
                         e_rdy, e_data, e_src, e_vld, e_busy);
            end

            fire = wrvld_a[k] && wrrdy;
            s    = int'(wrsrc_a[k]);
            if (fire) begin
                n_checks++;
                if (s >= X) begin
                    n_fail++;
                    $display("[TB] FAIL word_src dut%0d t=%0t: got src %0d expected below %0d", k, $time, s, X);
                end else begin
                    e_word = {8'(s), exp_seq[k][s]};
                    if (wrdata_a[k] !== e_word) begin
                        n_fail++;
                        $display("[TB] FAIL word_order dut%0d t=%0t: got %h expected %h", k, $time, wrdata_a[k], e_word);
                    end
                    exp_seq[k][s] = exp_seq[k][s] + 8'd1;
                end
            end

            for (int i = 0; i < X; i++) begin
                if (rst || !reqvld[i]) waitc[k][i] = 0;
                else if (fire && s == i) waitc[k][i] = 0;
                else if (fire) waitc[k][i] = waitc[k][i] + 1;
                if (!rst && reqvld[i]) begin
                    n_checks++;
                    if (waitc[k][i] > (X - 1) * bk) begin
                        n_fail++;
                        $display("[TB] FAIL fairness dut%0d req%0d t=%0t: got wait %0d expected at most %0d",
                                 k, i, $time, waitc[k][i], (X - 1) * bk);
                    end
                end
                if (reqvld[i] && reqrdy_a[k][i]) seq_drv[k][i] = seq_drv[k][i] + 8'd1;
            end

            // Burst-level model advance for the coming edge.
            if (rst) begin
                m_busy[k] = 0; m_owner[k] = 0; m_cnt[k] = 0; m_last[k] = X - 1;
            end else if (m_busy[k] == 0) begin
                if (reqvld != '0) begin
                    m_busy[k] = 1; m_owner[k] = rr(m_last[k], reqvld); m_cnt[k] = 0;
                end
            end else begin
                logic mf;
                mf = reqvld[m_owner[k]] && wrrdy;
                if (mf) m_cnt[k] = m_cnt[k] + 1;
                if ((mf && m_cnt[k] == bk) || !reqvld[m_owner[k]]) begin
                    m_last[k] = m_owner[k];
                    if (reqvld != '0) begin
                        m_owner[k] = rr(m_owner[k], reqvld); m_cnt[k] = 0;
                    end else begin
                        m_busy[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic [X-1:0] vld_v, input logic rdy_v);
        @(posedge clk);
        #1;
        rst    = rst_v;
        reqvld = vld_v;
        wrrdy  = rdy_v;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < X; i++) begin
                reqdata_a[k][i*W +: W] = {8'(i), seq_drv[k][i]};
            end
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 3'b011, 1'b1);
        applyStimulus(1'b1, 3'b011, 1'b1);
    endtask

    task automatic trackRun(input int k);
        if (wrvld_a[k] && wrrdy) begin
            if (int'(wrsrc_a[k]) == run_src[k]) begin
                run_len[k] = run_len[k] + 1;
            end else begin
                if (run_src[k] >= 0) checkLit("burst_len", k, run_len[k], k + 1);
                run_src[k] = int'(wrsrc_a[k]);
                run_len[k] = 1;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            reqdata_a[k] = '0;
            m_busy[k] = 0; m_owner[k] = 0; m_cnt[k] = 0; m_last[k] = X - 1;
            run_src[k] = -1; run_len[k] = 0;
            for (int i = 0; i < X; i++) begin
                seq_drv[k][i] = '0; exp_seq[k][i] = '0; waitc[k][i] = 0;
            end
        end

        doReset();
        for (int k = 0; k < NI; k++) begin
            checkLit("rst_busy", k, int'(busy_a[k]), 0);
            checkLit("rst_rdy", k, int'(reqrdy_a[k]), 0);
            checkLit("rst_vld", k, int'(wrvld_a[k]), 0);
        end

        // A lone requester keeps the port every cycle, re-granted with no bubble.
        applyStimulus(1'b0, 3'b001, 1'b1);
        for (int k = 0; k < NI; k++) checkLit("idle_after_rst", k, int'(busy_a[k]), 0);
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(1'b0, 3'b001, 1'b1);
            for (int k = 0; k < NI; k++) begin
                checkLit("single_src", k, int'(wrsrc_a[k]), 0);
                checkLit("single_vld", k, int'(wrvld_a[k] && busy_a[k]), 1);
            end
        end

        doReset();
        applyStimulus(1'b0, 3'b011, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(1'b0, 3'b011, 1'b1);
            for (int k = 0; k < NI; k++) begin
                checkLit("contend_src", k, int'(wrsrc_a[k]), ((c - 1) / (k + 1)) % 2);
                checkLit("contend_vld", k, int'(wrvld_a[k]), 1);
            end
        end

        doReset();
        applyStimulus(1'b0, 3'b011, 1'b1);
        for (int k = 0; k < NI; k++) begin
            run_src[k] = -1; run_len[k] = 0;
        end
        for (int c = 1; c <= 16; c++) begin
            logic r;
            r = (c % 2) == 1;
            applyStimulus(1'b0, 3'b011, r);
            for (int k = 0; k < NI; k++) begin
                if (!r) checkLit("stall_rdy", k, int'(reqrdy_a[k]), 0);
                else    checkLit("bp_rdy_onehot", k, $countones(reqrdy_a[k]), 1);
                trackRun(k);
            end
        end

        doReset();
        applyStimulus(1'b0, 3'b011, 1'b1);
        applyStimulus(1'b0, 3'b011, 1'b1);
        applyStimulus(1'b0, 3'b011, 1'b1);
        applyStimulus(1'b0, 3'b010, 1'b1);
        for (int k = 2; k < NI; k++) begin
            checkLit("early_vld", k, int'(wrvld_a[k]), 0);
            checkLit("early_busy", k, int'(busy_a[k]), 1);
        end
        applyStimulus(1'b0, 3'b010, 1'b1);
        for (int k = 2; k < NI; k++) begin
            checkLit("early_src", k, int'(wrsrc_a[k]), 1);
            checkLit("early_vld2", k, int'(wrvld_a[k]), 1);
        end

        doReset();
        applyStimulus(1'b0, 3'b011, 1'b1);
        applyStimulus(1'b0, 3'b011, 1'b1);
        applyStimulus(1'b0, 3'b011, 1'b1);
        applyStimulus(1'b1, 3'b011, 1'b1);
        for (int k = 0; k < NI; k++) begin
            checkLit("midrst_busy", k, int'(busy_a[k]), 0);
            checkLit("midrst_rdy", k, int'(reqrdy_a[k]), 0);
            checkLit("midrst_vld", k, int'(wrvld_a[k]), 0);
        end
        applyStimulus(1'b0, 3'b011, 1'b1);
        for (int k = 0; k < NI; k++) checkLit("post_rst_idle", k, int'(busy_a[k]), 0);
        applyStimulus(1'b0, 3'b011, 1'b1);
        for (int k = 0; k < NI; k++) begin
            checkLit("post_rst_src", k, int'(wrsrc_a[k]), 0);
            checkLit("post_rst_busy", k, int'(busy_a[k]), 1);
        end

        for (int c = 0; c < 1500; c++) begin
            logic [X-1:0] v;
            logic         rv;
            logic         rd;
            for (int i = 0; i < X; i++) v[i] = ($urandom_range(3) != 0);
            rv = ($urandom_range(99) == 0);
            rd = ($urandom_range(3) != 0);
            applyStimulus(rv, v, rd);
        end

        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < X; i++) begin
                checkLit("no_drop", k, int'(exp_seq[k][i]), int'(seq_drv[k][i]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
